// File: rtl/meta_queue_pkg.sv
// Shared metadata descriptor type and meta_queue sizing constants.
// Imported by flow_director consumers and by meta_queue itself.
package meta_queue_pkg;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [7:0]  queue_id;
    logic [15:0] pkt_len;
    logic [7:0]  flags;
  } metadata_t;

  localparam int unsigned META_W       = $bits(metadata_t);
  localparam int unsigned META_Q_DEPTH = 32;
  localparam int unsigned META_Q_AF    = 28;

endpackage

// File: rtl/meta_queue_chk.sv
// Simulation checks for meta_queue handshakes: no push when full,
// head descriptor held stable while stalled.
module meta_queue_chk #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DW     = 48
) (
  input logic              clk,
  input logic              rst,
  input logic              in_meta_valid,
  input logic              in_meta_ready,
  input logic              out_meta_valid,
  input logic              out_meta_ready,
  input logic [DW-1:0]     out_meta_data,
  input logic [AWIDTH:0]   occupancy
);

  localparam logic [AWIDTH:0] FULL_C = (AWIDTH+1)'(DEPTH);

  a_push_when_full: assert property (@(posedge clk) disable iff (rst)
    (in_meta_valid && in_meta_ready) |-> (occupancy != FULL_C))
    else $error("meta_queue: push while full");

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    $past(out_meta_valid && !out_meta_ready && !rst) |-> $stable(out_meta_data))
    else $error("meta_queue: out_meta_data changed while stalled");

endmodule

// File: rtl/meta_queue_ram.sv
// Simple dual-port descriptor storage: one write port, one registered read port.
// A write to the slot being read returns the new data (write-first).
module meta_queue_ram #(
  parameter int unsigned SLOTS  = 31,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DW     = 48
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DW-1:0]     rdata_o
);

  logic [DW-1:0] mem_q [SLOTS];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass keeps the registered head current when the head slot is written this cycle.
  always_ff @(posedge clk) begin
    rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/meta_queue.sv
// Elastic metadata FIFO: (DEPTH-1)-slot RAM plus a show-ahead output register.
// Optional counters enabled with META_QUEUE_STATS_EN.
module meta_queue
  import meta_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = META_Q_DEPTH,
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned AF_THRESH = META_Q_AF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [META_W-1:0]   in_meta_data,
  input  logic                in_meta_valid,
  output logic                in_meta_ready,
  output logic [META_W-1:0]   out_meta_data,
  output logic                out_meta_valid,
  input  logic                out_meta_ready,
  output logic [AWIDTH:0]     occupancy,
  output logic                almost_full,
  output logic [31:0]         stat_in_cnt,
  output logic [31:0]         stat_out_cnt
);

  localparam logic [AWIDTH:0]   DEPTH_C   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_C      = (AWIDTH+1)'(AF_THRESH);
  localparam logic [AWIDTH-1:0] LAST_SLOT = AWIDTH'(DEPTH-2);

  logic [META_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [AWIDTH:0]   occ_q, occ_d;
  logic              in_ready_q, in_ready_d;
  logic              af_q, af_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;

  logic              push_s, pop_s, load_out_s, ram_has_s, we_s;
  logic [AWIDTH:0]   ram_cnt_s;
  logic [META_W-1:0] ram_rdata_s;

  function automatic logic [AWIDTH-1:0] ptr_inc(input logic [AWIDTH-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + AWIDTH'(1);
  endfunction

  // Handshakes, output refill priority (RAM head, then bypass) and next state.
  always_comb begin
    push_s      = in_meta_valid & in_ready_q;
    pop_s       = out_valid_q & out_meta_ready;
    load_out_s  = pop_s | ~out_valid_q;
    ram_cnt_s   = occ_q - (AWIDTH+1)'(out_valid_q);
    ram_has_s   = (ram_cnt_s != '0);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    we_s        = 1'b0;
    if (load_out_s && ram_has_s) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata_s;
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      we_s        = push_s;
    end else if (load_out_s && push_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_meta_data;
    end else if (load_out_s) begin
      out_valid_d = 1'b0;
    end else begin
      we_s = push_s;
    end
    if (we_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    occ_d      = occ_q + (AWIDTH+1)'(push_s) - (AWIDTH+1)'(pop_s);
    in_ready_d = (occ_d < DEPTH_C);
    af_d       = (occ_d >= AF_C);
  end

  // Control and output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      occ_q       <= '0;
      in_ready_q  <= 1'b0;
      af_q        <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      occ_q       <= occ_d;
      in_ready_q  <= in_ready_d;
      af_q        <= af_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Read address is the next head so the registered read data is ready for the next pop.
  meta_queue_ram #(
    .SLOTS  (DEPTH-1),
    .AWIDTH (AWIDTH),
    .DW     (META_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_meta_data),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata_s)
  );

  meta_queue_chk #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH),
    .DW     (META_W)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .in_meta_valid  (in_meta_valid),
    .in_meta_ready  (in_ready_q),
    .out_meta_valid (out_valid_q),
    .out_meta_ready (out_meta_ready),
    .out_meta_data  (out_data_q),
    .occupancy      (occ_q)
  );

  assign in_meta_ready  = in_ready_q;
  assign out_meta_data  = out_data_q;
  assign out_meta_valid = out_valid_q;
  assign occupancy      = occ_q;
  assign almost_full    = af_q;

`ifdef META_QUEUE_STATS_EN
  logic [31:0] stat_in_q, stat_out_q;

  // Free-running handshake counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_in_q  <= 32'd0;
      stat_out_q <= 32'd0;
    end else begin
      stat_in_q  <= stat_in_q + 32'(push_s);
      stat_out_q <= stat_out_q + 32'(pop_s);
    end
  end

  assign stat_in_cnt  = stat_in_q;
  assign stat_out_cnt = stat_out_q;
`else
  assign stat_in_cnt  = 32'd0;
  assign stat_out_cnt = 32'd0;
`endif

endmodule
